fib_datapath: RTL and testbench
===============================

# fib_datapath

Execution datapath that consumes the per-cycle control word produced by the Fibonacci sequencing FSM and carries it out. Holds the 16×16 register file and a subset ALU, and drives the write-back bus from either the immediate value or the ALU result. It is the responder end of the controller→datapath interface. Internally it is a two-stage pipeline with bypass, so back-to-back dependent adds such as `add R1,R0` then `add R0,R1` execute at one per cycle.

## Interface
- `WIDTH`, 16: data width of registers, immediate and result.
- `NREGS`, 16: register count; the address width is log2(`NREGS`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears the pipeline, register file, flags and error state.
- `initial_r` in WIDTH: immediate value, written when `buff_ctrl`=4'b0001.
- `reg_write` in 4: destination register address.
- `reg_read1` in 4: operand A register address.
- `reg_read2` in 4: operand B register address.
- `alu_op` in 8: opcode from the shared package.
- `buff_ctrl` in 4: bus-drive select.
  - bit0: immediate drive.
  - bit1: ALU drive.
  - bit2: operand-A read drive.
  - bit3: operand-B read drive.
- `reg_reset` in 1: synchronous clear of the register file.
- `reg_write_en` in 1: write-back enable.
- `result` out WIDTH: registered write-back bus value.
- `result_valid` out 1: high for one cycle per committed write.
- `flags` out 4: {C, Z, N, V}.
- `bus_err` out 1: sticky illegal-`buff_ctrl` indicator.

## Operation
- Opcodes are defined in the shared package: NOP=8'h00, AND=8'h01, OR=8'h02, XOR=8'h03, ADD=8'h05, SUB=8'h09, MOV=8'h0D.
- MOV passes operand A through. Any undefined opcode behaves as NOP.
- Legal `buff_ctrl` patterns:
  - 4'b0001: immediate path. The result is `initial_r`; `alu_op` is ignored.
  - 4'b1110: ALU path. The result is ALU(A = R[`reg_read1`], B = R[`reg_read2`]).
- Any other `buff_ctrl` pattern:
  - The write is suppressed and flags hold.
  - `bus_err` sets and stays set until `reset`.
- Stage 1 (S1, capture), at each rising edge:
  - Registers the control word.
  - Reads operands A and B. The read value is bypassed from the S2 write data when S2 has a write pending to the same address.
- Stage 2 (S2, execute and write-back):
  - Computes the result combinationally.
  - At the next edge, writes R[dst] when `reg_write_en`=1 and the pattern is legal, and registers `result` and `result_valid`.
- Arithmetic is modulo 2^WIDTH.
  - ADD: C = carry-out.
  - SUB: computed as A + ~B + 1; C = NOT borrow.
  - V = signed overflow.
  - Z and N reflect the 16-bit result.
- Flag update rules:
  - ADD and SUB update all four flags.
  - AND, OR, XOR and MOV update Z and N only.
  - The immediate path and NOP leave flags unchanged.
- `reg_reset`=1 sampled at edge N:
  - All registers clear to 0 at edge N.
  - A pending S2 write at that edge is discarded (clear wins).
  - The op captured at edge N becomes a NOP bubble.
- `reg_write_en`=0 means no write and `result_valid`=0. `result` still updates, so the ALU can be observed.

## Timing
- Reset values: `result`=0, `result_valid`=0, `flags`=4'b0000, `bus_err`=0, all registers 0, both stages hold NOP.
- Latency: a control word sampled at edge N commits to the register file, `result` and `flags` at edge N+1. `result_valid` is high during the cycle after N+1.
- Throughput is one op per cycle with no stalls. The bypass covers the S2→S1 dependency, so there is no hazard gap.
- Simultaneous write and read of the same register in one cycle: the reader receives the new value through the bypass.
- Write to R[x] in the same cycle that `reg_reset` asserts: the register ends at 0.
- `reset` asserted mid-sequence: all state clears immediately (asynchronous). The first op after deassertion is sampled at the first rising edge with `reset` low.

## Structure
- Shared package `datapath_pkg` holds:
  - the opcode constants;
  - `BUF_IMM`=4'b0001 and `BUF_ALU`=4'b1110;
  - flag bit indices C=3, Z=2, N=1, V=0.
- One sub-module, `reg_file_16x16`:
  - two asynchronous read ports and one synchronous write port;
  - synchronous clear input;
  - asynchronous `reset`.
- The ALU stays inline; it is a single case statement.

## Test plan
- Immediate load: writes of 1 to R0 and then 1 to R1 (`buff_ctrl`=0001) → `result`=1 twice, R0=R1=1, flags unchanged.
- Fibonacci chain: after the immediate loads, alternate ADD R1←R0+R1 and R0←R1+R0 for 10 cycles → `result` sequence 2,3,5,8,13,21,34,55,89,144 with no bubbles, which proves the bypass.
- Wrap-around: R0=28657 and R1=46368, then ADD → `result`=9489, C=1, V=0, Z=0, N=0.
- SUB flags: R2=5 and R3=5, SUB R4←R2−R3 → `result`=0, Z=1, C=1, V=0.
- SUB signed overflow: 16'h8000−1 → `result`=16'h7FFF, V=1.
- Illegal bus: `buff_ctrl`=4'b0011 with `reg_write_en`=1 → no register change, `result_valid`=0, `bus_err`=1 held until `reset`.
- Clear and reset collisions, each as its own run:
  - `reg_reset` in the same cycle as a pending write to R5=7 → R5=0 and the next captured op is a bubble.
  - `reset` pulsed mid-chain → all outputs return to their reset values at once.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the Fibonacci controller/datapath pair: opcodes,
// bus-drive patterns, flag bit positions and the bus-pattern decoder.
package datapath_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_AND = 8'h01;
  localparam logic [7:0] OP_OR  = 8'h02;
  localparam logic [7:0] OP_XOR = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h05;
  localparam logic [7:0] OP_SUB = 8'h09;
  localparam logic [7:0] OP_MOV = 8'h0D;

  localparam logic [3:0] BUF_IMM = 4'b0001;
  localparam logic [3:0] BUF_ALU = 4'b1110;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Source of the write-back bus for one captured control word.
  typedef enum logic [1:0] {
    PATH_NONE,
    PATH_IMM,
    PATH_ALU,
    PATH_BAD
  } path_e;

  function automatic path_e decode_path(input logic [3:0] buff_ctrl);
    case (buff_ctrl)
      BUF_IMM: return PATH_IMM;
      BUF_ALU: return PATH_ALU;
      default: return PATH_BAD;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_16x16.sv
// Register file: two asynchronous read ports, one synchronous write port,
// synchronous bulk clear (which beats a same-edge write) and async reset.
module reg_file_16x16 #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] mem [NREGS];

  // NOTE: the array is reset on purpose -- the architecture guarantees every
  // register reads 0 after reset, so this must be flops, not an inferred RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/fib_datapath.sv
// Two-stage execution datapath: S1 captures the control word and operands
// (bypassed from S2), S2 executes and writes back at the following edge.
module fib_datapath
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] initial_r,
  input  logic [AW-1:0]    reg_write,
  input  logic [AW-1:0]    reg_read1,
  input  logic [AW-1:0]    reg_read2,
  input  logic [7:0]       alu_op,
  input  logic [3:0]       buff_ctrl,
  input  logic             reg_reset,
  input  logic             reg_write_en,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [3:0]       flags,
  output logic             bus_err
);

  path_e            s1_path;
  logic [7:0]       s1_op;
  logic [AW-1:0]    s1_dst;
  logic             s1_wen;
  logic [WIDTH-1:0] s1_imm, s1_a, s1_b;

  logic [WIDTH-1:0] rd1, rd2, a_fwd, b_fwd;
  logic [WIDTH-1:0] alu_y, s2_data;
  logic [WIDTH:0]   sum;
  logic             alu_c, alu_v, alu_act, alu_arith;
  logic             s2_commit, s2_write;
  logic [3:0]       flags_next;

  reg_file_16x16 #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .clear  (reg_reset),
    .we     (s2_write),
    .waddr  (s1_dst),
    .wdata  (s2_data),
    .raddr1 (reg_read1),
    .raddr2 (reg_read2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    alu_y     = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_act   = 1'b0;
    alu_arith = 1'b0;
    sum       = '0;
    case (s1_op)
      OP_AND: begin alu_y = s1_a & s1_b; alu_act = 1'b1; end
      OP_OR:  begin alu_y = s1_a | s1_b; alu_act = 1'b1; end
      OP_XOR: begin alu_y = s1_a ^ s1_b; alu_act = 1'b1; end
      OP_MOV: begin alu_y = s1_a;        alu_act = 1'b1; end
      OP_ADD: begin
        sum       = {1'b0, s1_a} + {1'b0, s1_b};
        alu_y     = sum[WIDTH-1:0];
        alu_c     = sum[WIDTH];
        alu_v     = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (alu_y[WIDTH-1] != s1_a[WIDTH-1]);
        alu_act   = 1'b1;
        alu_arith = 1'b1;
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the inverted borrow.
        sum       = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_y     = sum[WIDTH-1:0];
        alu_c     = sum[WIDTH];
        alu_v     = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (alu_y[WIDTH-1] != s1_a[WIDTH-1]);
        alu_act   = 1'b1;
        alu_arith = 1'b1;
      end
      default: ;
    endcase
  end

  assign s2_commit = (s1_path == PATH_IMM) || ((s1_path == PATH_ALU) && alu_act);
  assign s2_data   = (s1_path == PATH_IMM) ? s1_imm : alu_y;
  assign s2_write  = s2_commit && s1_wen;

  // The op retiring at this edge is the newest producer; readers take its data.
  assign a_fwd = (s2_write && (s1_dst == reg_read1)) ? s2_data : rd1;
  assign b_fwd = (s2_write && (s1_dst == reg_read2)) ? s2_data : rd2;

  always_comb begin
    flags_next = flags;
    if ((s1_path == PATH_ALU) && alu_act) begin
      flags_next[FLAG_Z] = (alu_y == '0);
      flags_next[FLAG_N] = alu_y[WIDTH-1];
      if (alu_arith) begin
        flags_next[FLAG_C] = alu_c;
        flags_next[FLAG_V] = alu_v;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_path <= PATH_NONE;
      s1_op   <= OP_NOP;
      s1_dst  <= '0;
      s1_wen  <= 1'b0;
      s1_imm  <= '0;
      s1_a    <= '0;
      s1_b    <= '0;
    end else begin
      s1_path <= reg_reset ? PATH_NONE : decode_path(buff_ctrl);
      s1_op   <= alu_op;
      s1_dst  <= reg_write;
      s1_wen  <= reg_write_en;
      s1_imm  <= initial_r;
      s1_a    <= a_fwd;
      s1_b    <= b_fwd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      flags        <= '0;
      bus_err      <= 1'b0;
    end else begin
      result_valid <= s2_write && !reg_reset;
      if (s2_commit) result <= s2_data;
      flags <= flags_next;
      if (s1_path == PATH_BAD) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fib_datapath.sv
// Self-checking bench for fib_datapath: architectural model (ops applied in
// program order, outputs one edge later) plus hand-computed literal checks.
module tb_fib_datapath;
  import datapath_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] initial_r;
  logic [3:0]  reg_write, reg_read1, reg_read2;
  logic [7:0]  alu_op;
  logic [3:0]  buff_ctrl;
  logic        reg_reset, reg_write_en;
  logic [15:0] result;
  logic        result_valid;
  logic [3:0]  flags;
  logic        bus_err;

  fib_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .initial_r    (initial_r),
    .reg_write    (reg_write),
    .reg_read1    (reg_read1),
    .reg_read2    (reg_read2),
    .alu_op       (alu_op),
    .buff_ctrl    (buff_ctrl),
    .reg_reset    (reg_reset),
    .reg_write_en (reg_write_en),
    .result       (result),
    .result_valid (result_valid),
    .flags        (flags),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  int          m_regs [16];
  logic [15:0] exp_result;
  logic        exp_valid, exp_err;
  logic [3:0]  exp_flags;
  logic        p_commit, p_write, p_bad;
  logic [15:0] p_data;
  logic [3:0]  p_dst, p_flags;

  function automatic int to_signed16(input int u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  function automatic void alu_model(input logic [7:0] op, input int a, input int b,
                                    input logic [3:0] f_in, output bit act,
                                    output int y, output logic [3:0] f);
    int full, s;
    act = 1'b1;
    f   = f_in;
    y   = 0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_MOV: y = a;
      OP_ADD: begin
        full = a + b;
        s    = to_signed16(a) + to_signed16(b);
        y    = full % 65536;
        f[FLAG_C] = full > 65535;
        f[FLAG_V] = (s > 32767) || (s < -32768);
      end
      OP_SUB: begin
        full = a + (65535 - b) + 1;
        s    = to_signed16(a) - to_signed16(b);
        y    = full % 65536;
        f[FLAG_C] = full > 65535;
        f[FLAG_V] = (s > 32767) || (s < -32768);
      end
      default: act = 1'b0;
    endcase
    f[FLAG_Z] = act ? (y == 0) : f_in[FLAG_Z];
    f[FLAG_N] = act ? (y >= 32768) : f_in[FLAG_N];
  endfunction

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    exp_result = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_flags = '0;
    p_commit = 1'b0; p_write = 1'b0; p_bad = 1'b0;
    p_data = '0; p_dst = '0; p_flags = '0;
  endtask

  // Called once per rising edge with the inputs that edge sampled.
  task automatic model_edge();
    bit act;
    int y;
    logic [3:0] f;
    if (p_commit) begin
      exp_result = p_data;
      exp_flags  = p_flags;
    end
    exp_valid = p_write && !reg_reset;
    if (p_bad) exp_err = 1'b1;
    if (p_write && !reg_reset) m_regs[p_dst] = int'(p_data);
    if (reg_reset) foreach (m_regs[i]) m_regs[i] = 0;
    p_commit = 1'b0; p_write = 1'b0; p_bad = 1'b0;
    if (!reg_reset) begin
      if (buff_ctrl == BUF_IMM) begin
        p_commit = 1'b1;
        p_data   = initial_r;
        p_flags  = exp_flags;
      end else if (buff_ctrl == BUF_ALU) begin
        alu_model(alu_op, m_regs[reg_read1], m_regs[reg_read2], exp_flags, act, y, f);
        p_commit = act;
        p_data   = 16'(y);
        p_flags  = f;
      end else begin
        p_bad = 1'b1;
      end
      p_write = p_commit && reg_write_en;
      p_dst   = reg_write;
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("result", 32'(result), 32'(exp_result));
    check("result_valid", 32'(result_valid), 32'(exp_valid));
    check("flags", 32'(flags), 32'(exp_flags));
    check("bus_err", 32'(bus_err), 32'(exp_err));
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] bc, input logic [7:0] op, input logic [3:0] wr,
                      input logic [3:0] r1, input logic [3:0] r2, input logic [15:0] imm,
                      input logic wen, input logic rr);
    buff_ctrl = bc; alu_op = op; reg_write = wr; reg_read1 = r1; reg_read2 = r2;
    initial_r = imm; reg_write_en = wen; reg_reset = rr;
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic load(input logic [3:0] dst, input logic [15:0] v);
    step(BUF_IMM, OP_NOP, dst, 4'd0, 4'd0, v, 1'b1, 1'b0);
  endtask

  task automatic alu(input logic [7:0] op, input logic [3:0] dst, input logic [3:0] a, input logic [3:0] b);
    step(BUF_ALU, op, dst, a, b, 16'd0, 1'b1, 1'b0);
  endtask

  task automatic peek(input logic [3:0] r);
    step(BUF_ALU, OP_MOV, 4'd0, r, 4'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic nop();
    step(BUF_ALU, OP_NOP, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0, 1'b0);
  endtask

  // Asserts reset in the middle of a clock-high phase and checks the
  // outputs clear before any further edge.
  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_result", 32'(result), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int fib_exp [10] = '{2, 3, 5, 8, 13, 21, 34, 55, 89, 144};

  initial begin
    reset = 1'b1;
    buff_ctrl = BUF_ALU; alu_op = OP_NOP; reg_write = '0; reg_read1 = '0; reg_read2 = '0;
    initial_r = '0; reg_write_en = 1'b0; reg_reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("init_result", 32'(result), 0);
    check("init_flags", 32'(flags), 0);

    // Immediate loads followed by the dependent add chain.
    load(4'd0, 16'd1);
    load(4'd1, 16'd1);
    check("imm_r0", 32'(result), 1);
    check("imm_r0_valid", 32'(result_valid), 1);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) alu(OP_ADD, 4'd1, 4'd0, 4'd1);
      else            alu(OP_ADD, 4'd0, 4'd1, 4'd0);
      if (i == 0) begin
        check("imm_r1", 32'(result), 1);
        check("imm_flags", 32'(flags), 0);
      end else begin
        check("fib", 32'(result), 32'(fib_exp[i-1]));
        check("fib_valid", 32'(result_valid), 1);
      end
    end
    nop();
    check("fib_last", 32'(result), 144);

    // Wrap-around add.
    load(4'd0, 16'd28657);
    load(4'd1, 16'd46368);
    alu(OP_ADD, 4'd2, 4'd0, 4'd1);
    nop();
    check("wrap_result", 32'(result), 9489);
    check("wrap_flags", 32'(flags), 32'b1000);

    // SUB to zero, then read the destination back.
    load(4'd2, 16'd5);
    load(4'd3, 16'd5);
    alu(OP_SUB, 4'd4, 4'd2, 4'd3);
    nop();
    check("sub_zero", 32'(result), 0);
    check("sub_zero_flags", 32'(flags), 32'b1100);
    load(4'd4, 16'hABCD);
    alu(OP_SUB, 4'd4, 4'd2, 4'd3);
    peek(4'd4);
    nop();
    check("sub_dst_readback", 32'(result), 0);

    // Signed overflow on SUB.
    load(4'd5, 16'h8000);
    load(4'd6, 16'd1);
    alu(OP_SUB, 4'd7, 4'd5, 4'd6);
    nop();
    check("sub_ovf_result", 32'(result), 32'h7FFF);
    check("sub_ovf_flags", 32'(flags), 32'b1001);

    // Logic ops keep C and V from the previous arithmetic op.
    load(4'd8, 16'hF0F0);
    load(4'd9, 16'h0FF0);
    alu(OP_XOR, 4'd10, 4'd8, 4'd9);
    nop();
    check("xor_result", 32'(result), 32'hFF00);
    check("xor_flags", 32'(flags), 32'b1011);

    // Illegal bus pattern: write suppressed, error sticky.
    step(4'b0011, OP_ADD, 4'd0, 4'd0, 4'd0, 16'd99, 1'b1, 1'b0);
    nop();
    check("bad_valid", 32'(result_valid), 0);
    check("bad_err", 32'(bus_err), 1);
    peek(4'd0);
    nop();
    check("bad_r0_kept", 32'(result), 28657);
    repeat (3) nop();
    check("bad_err_held", 32'(bus_err), 1);
    pulse_reset();

    // reg_reset against a pending write; the op captured with it is a bubble.
    load(4'd5, 16'd7);
    step(BUF_IMM, OP_NOP, 4'd6, 4'd0, 4'd0, 16'd9, 1'b1, 1'b1);
    check("clr_valid", 32'(result_valid), 0);
    nop();
    check("bubble_valid", 32'(result_valid), 0);
    peek(4'd5);
    peek(4'd6);
    check("clr_r5", 32'(result), 0);
    nop();
    check("bubble_r6", 32'(result), 0);

    // Reset pulsed in the middle of a chain.
    load(4'd0, 16'd1);
    load(4'd1, 16'd1);
    alu(OP_ADD, 4'd1, 4'd0, 4'd1);
    alu(OP_ADD, 4'd0, 4'd1, 4'd0);
    alu(OP_ADD, 4'd1, 4'd0, 4'd1);
    pulse_reset();
    peek(4'd1);
    nop();
    check("post_rst_r1", 32'(result), 0);
    nop();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1);
  end

endmodule
